// File: rtl/parking_lot_ctrl.sv
// parking_lot_ctrl
//   Multi-lane car-park controller. Each lane runs an entry/exit sequence FSM
//   on an outer (a) / inner (b) beam-sensor pair. Completed sequences are
//   arbitrated against a shared, saturating occupancy counter.
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   a, b       per-lane outer / inner sensor, 1 = blocked (clk-synchronous)
//   entry      1-cycle pulse, accepted entry on lane i
//   exit       1-cycle pulse, accepted exit on lane i
//   reject     1-cycle pulse, entry completed on lane i with no space left
//   underflow  1-cycle pulse, at least one exit completed with nothing to leave
//   lane_fault 1-cycle pulse, lane i sat too long in a non-idle state
//   count      current occupancy (0..CAPACITY)
//   full       count == CAPACITY
//   empty      count == 0
module parking_lot_ctrl #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned CAPACITY = 15,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  output logic [LANES-1:0] entry,
  output logic [LANES-1:0] exit,
  output logic [LANES-1:0] reject,
  output logic             underflow,
  output logic [LANES-1:0] lane_fault,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned    TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TMAX  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]  TONE  = TW'(1);
  localparam logic [CNT_W-1:0] CAP_W = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_E1, S_E2, S_E3, S_X1, S_X2, S_X3, S_WAIT
  } state_t;

  state_t           state_q [LANES];
  state_t           state_d [LANES];
  logic [TW-1:0]    timer_q [LANES];
  logic [TW-1:0]    timer_d [LANES];
  logic [LANES-1:0] fault_d;
  logic [LANES-1:0] done_e;
  logic [LANES-1:0] done_x;
  logic [LANES-1:0] entry_d;
  logic [LANES-1:0] exit_d;
  logic [LANES-1:0] reject_d;
  logic             underflow_d;
  logic [CNT_W-1:0] cnt_next;

  // Sensor-pattern transition table; any pattern not listed falls to WAIT.
  function automatic state_t lane_step(input state_t s, input logic [1:0] ab);
    state_t n;
    n = S_WAIT;
    case (s)
      S_IDLE: case (ab)
        2'b00:   n = S_IDLE;
        2'b10:   n = S_E1;
        2'b01:   n = S_X1;
        default: n = S_WAIT;
      endcase
      S_E1: case (ab)
        2'b10:   n = S_E1;
        2'b11:   n = S_E2;
        2'b00:   n = S_IDLE;
        default: n = S_WAIT;
      endcase
      S_E2: case (ab)
        2'b11:   n = S_E2;
        2'b01:   n = S_E3;
        2'b10:   n = S_E1;
        default: n = S_WAIT;
      endcase
      S_E3: case (ab)
        2'b01:   n = S_E3;
        2'b11:   n = S_E2;
        2'b00:   n = S_IDLE;
        default: n = S_WAIT;
      endcase
      S_X1: case (ab)
        2'b01:   n = S_X1;
        2'b11:   n = S_X2;
        2'b00:   n = S_IDLE;
        default: n = S_WAIT;
      endcase
      S_X2: case (ab)
        2'b11:   n = S_X2;
        2'b10:   n = S_X3;
        2'b01:   n = S_X1;
        default: n = S_WAIT;
      endcase
      S_X3: case (ab)
        2'b10:   n = S_X3;
        2'b11:   n = S_X2;
        2'b00:   n = S_IDLE;
        default: n = S_WAIT;
      endcase
      default: n = (ab == 2'b00) ? S_IDLE : S_WAIT;
    endcase
    return n;
  endfunction

  // State register, timers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
      end
      entry      <= '0;
      exit       <= '0;
      reject     <= '0;
      underflow  <= 1'b0;
      lane_fault <= '0;
      count      <= '0;
      full       <= 1'b0;
      empty      <= 1'b1;
    end else begin
      for (int unsigned i = 0; i < LANES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      entry      <= entry_d;
      exit       <= exit_d;
      reject     <= reject_d;
      underflow  <= underflow_d;
      lane_fault <= fault_d;
      count      <= cnt_next;
      full       <= (cnt_next == CAP_W);
      empty      <= (cnt_next == '0);
    end
  end

  // Next state. A genuine state change has priority over the timeout, so a
  // completion on the last allowed cycle is never lost.
  always_comb begin : next_state
    state_t raw;
    fault_d = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      raw        = lane_step(state_q[i], {a[i], b[i]});
      state_d[i] = raw;
      timer_d[i] = '0;
      if (raw == state_q[i] && state_q[i] != S_IDLE) begin
        if (timer_q[i] == TMAX) begin
          state_d[i] = S_WAIT;
          fault_d[i] = 1'b1;
        end else begin
          timer_d[i] = timer_q[i] + TONE;
        end
      end
    end
  end

  // Completion decode and occupancy arbitration.
  // Exits are served first against the current count (lowest lane first),
  // entries then fill the space left after the accepted exits.
  always_comb begin : outputs
    logic [CNT_W-1:0] x_left;
    logic [CNT_W-1:0] room;
    done_e      = '0;
    done_x      = '0;
    entry_d     = '0;
    exit_d      = '0;
    reject_d    = '0;
    underflow_d = 1'b0;
    x_left      = count;
    for (int unsigned i = 0; i < LANES; i++) begin
      done_e[i] = (state_q[i] == S_E3) && ({a[i], b[i]} == 2'b00);
      done_x[i] = (state_q[i] == S_X3) && ({a[i], b[i]} == 2'b00);
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      if (done_x[i]) begin
        if (x_left != '0) begin
          exit_d[i] = 1'b1;
          x_left    = x_left - CONE;
        end else begin
          underflow_d = 1'b1;
        end
      end
    end
    room     = CAP_W - x_left;
    cnt_next = x_left;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (done_e[i]) begin
        if (room != '0) begin
          entry_d[i] = 1'b1;
          room       = room - CONE;
          cnt_next   = cnt_next + CONE;
        end else begin
          reject_d[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Bench for parking_lot_ctrl: table-driven vectors, directed multi-cycle
// sequences, and a random phase against a position-based reference model.
module tb_parking_lot_ctrl;

  localparam int L   = 3;
  localparam int CAP = 15;
  localparam int T   = 20;

  logic         clk;
  logic         rst;
  logic [L-1:0] a_i, b_i;
  logic [L-1:0] entry_o, exit_o, reject_o, fault_o;
  logic         uf_o, full_o, empty_o;
  logic [3:0]   count_o;

  int n_chk  = 0;
  int n_fail = 0;

  parking_lot_ctrl #(
    .LANES   (L),
    .CAPACITY(CAP),
    .CNT_W   (4),
    .TIMEOUT (T)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .a         (a_i),
    .b         (b_i),
    .entry     (entry_o),
    .exit      (exit_o),
    .reject    (reject_o),
    .underflow (uf_o),
    .lane_fault(fault_o),
    .count     (count_o),
    .full      (full_o),
    .empty     (empty_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [L-1:0] a;
    logic [L-1:0] b;
    logic [L-1:0] e;
    logic [L-1:0] x;
    logic [3:0]   c;
  } vec_t;

  vec_t tbl[$];

  task automatic check_out(input string tag, input logic [L-1:0] e, x, r,
                           input logic uf, input logic [L-1:0] f, input logic [3:0] c);
    n_chk++;
    if (entry_o !== e) begin n_fail++; $display("FAIL %s entry: got %b want %b", tag, entry_o, e); end
    n_chk++;
    if (exit_o !== x) begin n_fail++; $display("FAIL %s exit: got %b want %b", tag, exit_o, x); end
    n_chk++;
    if (reject_o !== r) begin n_fail++; $display("FAIL %s reject: got %b want %b", tag, reject_o, r); end
    n_chk++;
    if (uf_o !== uf) begin n_fail++; $display("FAIL %s underflow: got %b want %b", tag, uf_o, uf); end
    n_chk++;
    if (fault_o !== f) begin n_fail++; $display("FAIL %s lane_fault: got %b want %b", tag, fault_o, f); end
    n_chk++;
    if (count_o !== c) begin n_fail++; $display("FAIL %s count: got %0d want %0d", tag, count_o, c); end
    n_chk++;
    if (full_o !== (c == 4'(CAP))) begin n_fail++; $display("FAIL %s full: got %b want %b", tag, full_o, (c == 4'(CAP))); end
    n_chk++;
    if (empty_o !== (c == 4'd0)) begin n_fail++; $display("FAIL %s empty: got %b want %b", tag, empty_o, (c == 4'd0)); end
  endtask

  task automatic step(input logic [L-1:0] av, bv);
    @(negedge clk);
    a_i = av;
    b_i = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    a_i = '0;
    b_i = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Full entry sequence on lanes in me and exit sequence on lanes in mx, in
  // parallel. Intermediate cycles must be quiet at count c; caller checks the
  // completion cycle.
  task automatic drive(input logic [L-1:0] me, mx, input logic [3:0] c);
    step(me, mx);
    check_out("seq1", '0, '0, '0, 1'b0, '0, c);
    step(me | mx, me | mx);
    check_out("seq2", '0, '0, '0, 1'b0, '0, c);
    step(mx, me);
    check_out("seq3", '0, '0, '0, 1'b0, '0, c);
    step('0, '0);
  endtask

  // Reference model: a lane is idle (0), carrying a car inward (1) or
  // outward (2), or waiting for a clear beam (3). pos is how far along its
  // direction the car is (1..3); a car may only move one position per cycle.
  int m_mode[L];
  int m_pos[L];
  int m_age[L];
  int m_cnt;

  function automatic int along(input int mode, input int ab);
    if (ab == 0) return 0;
    if (mode == 1) return (ab == 2) ? 1 : (ab == 3) ? 2 : 3;
    return (ab == 1) ? 1 : (ab == 3) ? 2 : 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < L; i++) begin
      m_mode[i] = 0;
      m_pos[i]  = 0;
      m_age[i]  = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_step(input logic [L-1:0] av, bv,
                            output logic [L-1:0] e, x, r, f, output logic uf);
    logic [L-1:0] ce, cx;
    int ab, nm, np, q, acc_x, acc_e, space;
    ce = '0; cx = '0; e = '0; x = '0; r = '0; f = '0; uf = 1'b0;
    for (int i = 0; i < L; i++) begin
      ab = 2 * int'(av[i]) + int'(bv[i]);
      nm = m_mode[i];
      np = m_pos[i];
      if (m_mode[i] == 0) begin
        if (ab == 2) begin nm = 1; np = 1; end
        else if (ab == 1) begin nm = 2; np = 1; end
        else if (ab == 3) begin nm = 3; np = 0; end
      end else if (m_mode[i] == 3) begin
        if (ab == 0) begin nm = 0; np = 0; end
      end else begin
        q = along(m_mode[i], ab);
        if (q == 0) begin
          if (m_pos[i] == 1) begin
            nm = 0; np = 0;
          end else if (m_pos[i] == 3) begin
            if (m_mode[i] == 1) ce[i] = 1'b1; else cx[i] = 1'b1;
            nm = 0; np = 0;
          end else begin
            nm = 3; np = 0;
          end
        end else if (q - m_pos[i] >= -1 && q - m_pos[i] <= 1) begin
          np = q;
        end else begin
          nm = 3; np = 0;
        end
      end
      if (nm == m_mode[i] && np == m_pos[i] && nm != 0) begin
        if (m_age[i] == T - 1) begin
          f[i] = 1'b1; nm = 3; np = 0; m_age[i] = 0;
        end else begin
          m_age[i]++;
        end
      end else begin
        m_age[i] = 0;
      end
      m_mode[i] = nm;
      m_pos[i]  = np;
    end
    acc_x = 0;
    for (int i = 0; i < L; i++)
      if (cx[i]) begin
        if (acc_x < m_cnt) begin x[i] = 1'b1; acc_x++; end
        else uf = 1'b1;
      end
    space = CAP - (m_cnt - acc_x);
    acc_e = 0;
    for (int i = 0; i < L; i++)
      if (ce[i]) begin
        if (acc_e < space) begin e[i] = 1'b1; acc_e++; end
        else r[i] = 1'b1;
      end
    m_cnt = m_cnt - acc_x + acc_e;
  endtask

  initial begin
    logic [L-1:0] me, mx, mr, mf;
    logic         mu;
    logic [L-1:0] ra, rb;
    int           idx[L];
    int           dir[L];
    int           rr;

    rst = 1'b1;
    a_i = '0;
    b_i = '0;
    #2 rst = 1'b0;
    #1;
    check_out("reset", '0, '0, '0, 1'b0, '0, 4'd0);
    @(negedge clk);
    rst = 1'b1;

    // Vector table: a, b, expected entry, exit, count.
    tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 4'd0});
    tbl.push_back('{3'b001, 3'b000, 3'b000, 3'b000, 4'd0});
    tbl.push_back('{3'b001, 3'b001, 3'b000, 3'b000, 4'd0});
    tbl.push_back('{3'b000, 3'b001, 3'b000, 3'b000, 4'd0});
    tbl.push_back('{3'b000, 3'b000, 3'b001, 3'b000, 4'd1});
    tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b001, 3'b000, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b001, 3'b001, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b001, 3'b000, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b111, 3'b000, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b111, 3'b111, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b000, 3'b111, 3'b000, 3'b000, 4'd1});
    tbl.push_back('{3'b000, 3'b000, 3'b111, 3'b000, 4'd4});
    tbl.push_back('{3'b000, 3'b010, 3'b000, 3'b000, 4'd4});
    tbl.push_back('{3'b010, 3'b010, 3'b000, 3'b000, 4'd4});
    tbl.push_back('{3'b010, 3'b000, 3'b000, 3'b000, 4'd4});
    tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b010, 4'd3});
    tbl.push_back('{3'b001, 3'b001, 3'b000, 3'b000, 4'd3});
    tbl.push_back('{3'b001, 3'b000, 3'b000, 3'b000, 4'd3});
    tbl.push_back('{3'b000, 3'b001, 3'b000, 3'b000, 4'd3});
    tbl.push_back('{3'b000, 3'b000, 3'b000, 3'b000, 4'd3});
    foreach (tbl[k]) begin
      step(tbl[k].a, tbl[k].b);
      check_out($sformatf("vec%0d", k), tbl[k].e, tbl[k].x, '0, 1'b0, '0, tbl[k].c);
    end

    // Exit at count 0 is dropped with underflow; two exits at count 1 clamp.
    do_reset();
    drive('0, 3'b010, 4'd0);
    check_out("uf_zero", '0, '0, '0, 1'b1, '0, 4'd0);
    step('0, '0);
    check_out("uf_clear", '0, '0, '0, 1'b0, '0, 4'd0);
    drive(3'b001, '0, 4'd0);
    check_out("one_in", 3'b001, '0, '0, 1'b0, '0, 4'd1);
    drive('0, 3'b110, 4'd1);
    check_out("uf_clamp", '0, 3'b010, '0, 1'b1, '0, 4'd0);

    // Capacity boundary.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(3'b111, '0, 4'(3 * k));
      check_out("fill", 3'b111, '0, '0, 1'b0, '0, 4'(3 * k + 3));
    end
    drive(3'b011, '0, 4'd12);
    check_out("fill14", 3'b011, '0, '0, 1'b0, '0, 4'd14);
    drive(3'b011, '0, 4'd14);
    check_out("cap_rej", 3'b001, '0, 3'b010, 1'b0, '0, 4'd15);
    step('0, '0);
    check_out("cap_hold", '0, '0, '0, 1'b0, '0, 4'd15);
    drive('0, 3'b001, 4'd15);
    check_out("cap_out", '0, 3'b001, '0, 1'b0, '0, 4'd14);
    drive(3'b011, 3'b100, 4'd14);
    check_out("cap_swap", 3'b011, 3'b100, '0, 1'b0, '0, 4'd15);

    // Timeout: lane 0 stuck at 11, faults at edge T+1 and every T after.
    for (int k = 1; k <= 2 * T + 1; k++) begin
      step(3'b001, 3'b001);
      check_out($sformatf("tmo%0d", k), '0, '0, '0, 1'b0,
                (k == T + 1 || k == 2 * T + 1) ? 3'b001 : 3'b000, 4'd15);
    end
    step('0, '0);
    check_out("tmo_rel", '0, '0, '0, 1'b0, '0, 4'd15);
    drive('0, 3'b001, 4'd15);
    check_out("tmo_after", '0, 3'b001, '0, 1'b0, '0, 4'd14);

    // Reset in the middle of an entry sequence.
    do_reset();
    drive(3'b111, '0, 4'd0);
    check_out("mid3", 3'b111, '0, '0, 1'b0, '0, 4'd3);
    drive(3'b011, '0, 4'd3);
    check_out("mid5", 3'b011, '0, '0, 1'b0, '0, 4'd5);
    step(3'b001, 3'b000);
    step(3'b001, 3'b001);
    check_out("mid_e2", '0, '0, '0, 1'b0, '0, 4'd5);
    rst = 1'b0;
    #1;
    check_out("mid_rst", '0, '0, '0, 1'b0, '0, 4'd0);
    @(negedge clk);
    rst = 1'b1;
    step(3'b000, 3'b001);
    check_out("mid_e3", '0, '0, '0, 1'b0, '0, 4'd0);
    step('0, '0);
    check_out("mid_done", '0, '0, '0, 1'b0, '0, 4'd0);
    drive(3'b001, '0, 4'd0);
    check_out("mid_new", 3'b001, '0, '0, 1'b0, '0, 4'd1);

    // Random walks through the sensor cycle 00,10,11,01 (forward = entering,
    // backward = leaving), with holds and occasional glitches.
    do_reset();
    model_reset();
    for (int i = 0; i < L; i++) begin
      idx[i] = 0;
      dir[i] = 1;
    end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < L; i++) begin
        rr = $urandom_range(0, 19);
        if (rr >= 8 && rr < 18) begin
          if (idx[i] == 0)
            dir[i] = ($urandom_range(0, 99) < ((n < 1500) ? 65 : 35)) ? 1 : 3;
          idx[i] = (idx[i] + dir[i]) % 4;
        end else if (rr == 18) begin
          idx[i] = $urandom_range(0, 3);
        end
        ra[i] = (idx[i] == 1 || idx[i] == 2);
        rb[i] = (idx[i] == 2 || idx[i] == 3);
      end
      step(ra, rb);
      model_step(ra, rb, me, mx, mr, mf, mu);
      check_out("rand", me, mx, mr, mu, mf, 4'(m_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
